pc_next_sel: RTL and testbench

//  Parametrised successor of the 4:1 jump-address mux: registered next-PC selector for the fetch stage.

---
 rtl/pc_next_sel.sv | 113 +++++++++++
 tb/tb_pc_next_sel.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pc_next_sel.sv
// Registered next-PC selector for fetch: sequential step or priority redirect.
// Optional PC_ALIGN_CHECK_EN forces loaded targets word-aligned and flags misalign.
module pc_next_sel #(
  parameter int ADDR_W   = 18,
  parameter int NUM_SRC  = 4,
  parameter int SRC_W    = 2,
  parameter int PC_STEP  = 4,
  parameter int RESET_PC = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0]         pc_out,
  output logic                      redirect,
  output logic [SRC_W-1:0]          redirect_src,
  output logic                      pend_valid,
  output logic                      misalign
);

  logic              has;
  logic [SRC_W-1:0]  win;
  logic [ADDR_W-1:0] win_addr;
  logic [ADDR_W-1:0] pend_addr;
  logic [SRC_W-1:0]  pend_src;
  logic              ld;
  logic [ADDR_W-1:0] ld_addr;
  logic [SRC_W-1:0]  ld_src;
  logic              cap;

  // Highest-index valid source wins; later loop iterations override.
  always_comb begin
    has = 1'b0;
    win = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i]) begin
        has = 1'b1;
        win = SRC_W'(i);
      end
    end
    win_addr = src_addr[win*ADDR_W +: ADDR_W];
  end

  // Choose load target: a fresh winner beats a strictly lower pending one.
  always_comb begin
    ld      = 1'b0;
    ld_addr = win_addr;
    ld_src  = win;
    cap     = 1'b0;
    if (stall) begin
      cap = has && (!pend_valid || win >= pend_src);
    end else if (pend_valid) begin
      ld = 1'b1;
      if (!(has && win > pend_src)) begin
        ld_addr = pend_addr;
        ld_src  = pend_src;
      end
    end else begin
      ld = has;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic [ADDR_W-1:0] ld_pc;
  logic              ld_mis;
  assign ld_pc  = {ld_addr[ADDR_W-1:2], 2'b00};
  assign ld_mis = |ld_addr[1:0];
`else
  logic [ADDR_W-1:0] ld_pc;
  logic              ld_mis;
  assign ld_pc  = ld_addr;
  assign ld_mis = 1'b0;
`endif

  // PC, redirect pulse and alignment flag update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out       <= ADDR_W'(RESET_PC);
      redirect     <= 1'b0;
      redirect_src <= '0;
      misalign     <= 1'b0;
    end else if (stall) begin
      redirect <= 1'b0;
      misalign <= 1'b0;
    end else if (ld) begin
      pc_out       <= ld_pc;
      redirect     <= 1'b1;
      redirect_src <= ld_src;
      misalign     <= ld_mis;
    end else begin
      pc_out   <= pc_out + ADDR_W'(PC_STEP);
      redirect <= 1'b0;
      misalign <= 1'b0;
    end
  end

  // One-entry redirect buffer used while stalled; raw address kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_src   <= '0;
    end else if (cap) begin
      pend_valid <= 1'b1;
      pend_addr  <= win_addr;
      pend_src   <= win;
    end else if (!stall) begin
      pend_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_next_sel.sv
// Directed self-checking bench for pc_next_sel.
// Honours PC_ALIGN_CHECK_EN for the misalign expectations.
module tb_pc_next_sel;

  localparam int AW = 18;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic [NS-1:0] src_valid;
  logic [AW-1:0] addr [NS];
  logic [NS*AW-1:0] src_addr;
  logic [AW-1:0] pc_out;
  logic          redirect;
  logic [1:0]    redirect_src;
  logic          pend_valid;
  logic          misalign;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign src_addr = {addr[3], addr[2], addr[1], addr[0]};

  pc_next_sel dut (
    .clk(clk), .rst(rst), .stall(stall),
    .src_valid(src_valid), .src_addr(src_addr),
    .pc_out(pc_out), .redirect(redirect),
    .redirect_src(redirect_src),
    .pend_valid(pend_valid), .misalign(misalign)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag,
                    input logic [AW-1:0] pc,
                    input logic rd,
                    input logic [1:0] rs,
                    input logic pv);
    chk({tag, ".pc"}, 32'(pc_out), 32'(pc));
    chk({tag, ".rd"}, 32'(redirect), 32'(rd));
    chk({tag, ".rs"}, 32'(redirect_src), 32'(rs));
    chk({tag, ".pv"}, 32'(pend_valid), 32'(pv));
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    src_valid = '0;
    for (int i = 0; i < NS; i++) addr[i] = '0;
    #2;
    st("rst", 18'h0, 0, 0, 0);
    chk("rst.mis", 32'(misalign), 0);
    @(negedge clk);
    rst = 1'b0;

    // sequential run
    step(); st("seq1", 18'h4, 0, 0, 0);
    step(); st("seq2", 18'h8, 0, 0, 0);
    step(); st("seq3", 18'hC, 0, 0, 0);
    step(); st("seq4", 18'h10, 0, 0, 0);

    // priority among simultaneous requests
    addr[1] = 18'h100;
    addr[2] = 18'h200;
    src_valid = 4'b0110;
    step(); st("prio", 18'h200, 1, 2, 0);
    src_valid = '0;
    step(); st("after", 18'h204, 0, 2, 0);

    // lower-priority request while pending is dropped
    stall = 1'b1;
    addr[1] = 18'h40;
    src_valid = 4'b0010;
    step(); st("stA", 18'h204, 0, 2, 1);
    addr[0] = 18'h80;
    src_valid = 4'b0001;
    step(); st("stB", 18'h204, 0, 2, 1);
    stall = 1'b0;
    src_valid = '0;
    step(); st("rel", 18'h40, 1, 1, 0);

    // higher-priority request on release overrides pending
    stall = 1'b1;
    src_valid = 4'b0010;
    step(); st("p4", 18'h40, 0, 1, 1);
    stall = 1'b0;
    addr[3] = 18'h300;
    src_valid = 4'b1000;
    step(); st("ovr", 18'h300, 1, 3, 0);

    // same priority newest wins; lower on release loses to pending
    stall = 1'b1;
    addr[1] = 18'h50;
    src_valid = 4'b0010;
    step(); st("sp1", 18'h300, 0, 3, 1);
    addr[1] = 18'h60;
    step(); st("sp2", 18'h300, 0, 3, 1);
    stall = 1'b0;
    src_valid = 4'b0001;
    step(); st("sprel", 18'h60, 1, 1, 0);

    // wrap at top of address space
    addr[0] = 18'h3FFFC;
    src_valid = 4'b0001;
    step(); st("top", 18'h3FFFC, 1, 0, 0);
    src_valid = '0;
    step(); st("wrap", 18'h0, 0, 0, 0);
    step(); st("wrap2", 18'h4, 0, 0, 0);

    // reset mid-stall discards pending; src ignored under reset
    stall = 1'b1;
    src_valid = 4'b0100;
    step(); st("prst", 18'h4, 0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    st("arst", 18'h0, 0, 0, 0);
    stall = 1'b0;
    step(); st("inrst", 18'h0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    src_valid = '0;
    step(); st("post", 18'h4, 0, 0, 0);

    // misaligned redirect target
    addr[1] = 18'h103;
    src_valid = 4'b0010;
    step();
`ifdef PC_ALIGN_CHECK_EN
    st("mis", 18'h100, 1, 1, 0);
    chk("mis.flag", 32'(misalign), 1);
`else
    st("mis", 18'h103, 1, 1, 0);
    chk("mis.flag", 32'(misalign), 0);
`endif
    src_valid = '0;
    step();
    chk("mis.clr", 32'(misalign), 0);
    chk("mis.rd", 32'(redirect), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
